// File: rtl/fir_n_inverse.sv
// -----------------------------------------------------------------------------
// fir_n_inverse
//
// Inverse (deconvolution) filter for a monic transversal FIR. Recovers x[n]
// from y[n] = sum_{k=0..DELAYS} b_k*x[n-k] (mod 2^N), where b0 is taken as 1:
//
//     x[n] = y[n] - sum_{k=1..DELAYS} b_k * x[n-k]      (all arithmetic mod 2^N)
//
// A single multiplier is time-shared across the taps by a small FSM:
//   IDLE : accept y_in, latch b, seed acc with y_in
//   ACC  : DELAYS cycles, one tap per cycle: acc -= low_N(b_k * x[n-k])
//   OUT  : present acc on x_out until x_ready, then push it into the history
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active high
//   y_in     : filtered sample (signed, N bits)
//   y_valid  : y_in valid
//   y_ready  : block can take y_in (IDLE and not in reset)
//   b        : packed taps, b_k = b[(k+1)*N-1 : k*N]; b0 is ignored
//   clr      : synchronous history clear / abort of any in-flight sample
//   x_out    : recovered sample (signed, N bits)
//   x_valid  : x_out valid
//   x_ready  : downstream accepts x_out
// -----------------------------------------------------------------------------
module fir_n_inverse #(
    parameter int DELAYS = 3,
    parameter int N      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            y_in,
    input  logic                    y_valid,
    output logic                    y_ready,
    input  logic [(DELAYS+1)*N-1:0] b,
    input  logic                    clr,
    output logic [N-1:0]            x_out,
    output logic                    x_valid,
    input  logic                    x_ready
);

    localparam int KW = $clog2(DELAYS + 1);  // holds tap numbers 1..DELAYS
    localparam int IW = $clog2(DELAYS);      // indexes taps 0..DELAYS-1

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                   state_q;
    logic [N-1:0]             acc_q;
    logic [KW-1:0]            k_q;
    logic [DELAYS-1:0][N-1:0] b_reg_q;   // element j holds tap b_(j+1)
    logic [DELAYS-1:0][N-1:0] hist_q;    // element j holds x[n-1-j]

    logic [IW-1:0]            tap_d;
    logic [N-1:0]             prod_d;
    logic [N-1:0]             acc_d;

    // b0 is fixed at 1 by construction of the forward filter, so its bits are
    // deliberately not used.
    logic                     b0_unused;
    assign b0_unused = ^b[N-1:0];

    // Tap k pairs b_k with x[n-k], both stored at index k-1. The N-bit product
    // keeps only the low N bits, which is identical for signed and unsigned
    // operands, so no sign handling is needed anywhere in the datapath.
    assign tap_d  = IW'(k_q - KW'(1));
    assign prod_d = b_reg_q[tap_d] * hist_q[tap_d];
    assign acc_d  = acc_q - prod_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            k_q     <= KW'(1);
            b_reg_q <= '0;
            hist_q  <= '0;
        end else if (clr) begin
            // Abort wins over any handshake in the same cycle.
            state_q <= IDLE;
            acc_q   <= '0;
            k_q     <= KW'(1);
            hist_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (y_valid) begin
                        acc_q   <= y_in;
                        b_reg_q <= b[(DELAYS+1)*N-1:N];
                        k_q     <= KW'(1);
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    acc_q <= acc_d;
                    if (k_q == KW'(DELAYS)) begin
                        k_q     <= KW'(1);
                        state_q <= OUT;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                OUT: begin
                    if (x_ready) begin
                        hist_q  <= {hist_q[DELAYS-2:0], acc_q};
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registers; y_ready also drops combinationally
    // with rst so nothing is accepted while reset is held.
    assign y_ready = (state_q == IDLE) && !rst;
    assign x_valid = (state_q == OUT);
    assign x_out   = acc_q;

endmodule

// File: tb/tb_fir_n_inverse.sv
// -----------------------------------------------------------------------------
// tb_fir_n_inverse
//
// Directed bench for fir_n_inverse (DELAYS=3, N=32). Expected samples are
// queued when the matching y_in is handed over; a monitor pops and compares
// them whenever an x_valid/x_ready handshake is about to occur.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_fir_n_inverse;

    localparam int DELAYS = 3;
    localparam int N      = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            y_in;
    logic                    y_valid;
    logic                    y_ready;
    logic [(DELAYS+1)*N-1:0] b;
    logic                    clr;
    logic [N-1:0]            x_out;
    logic                    x_valid;
    logic                    x_ready;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] mon_exp;
    logic [N-1:0] mh [DELAYS];   // reference history for the random section

    always #5 clk = ~clk;

    fir_n_inverse #(.DELAYS(DELAYS), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .y_in    (y_in),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .b       (b),
        .clr     (clr),
        .x_out   (x_out),
        .x_valid (x_valid),
        .x_ready (x_ready)
    );

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [(DELAYS+1)*N-1:0] mkb(input logic [N-1:0] b3, input logic [N-1:0] b2,
                                                     input logic [N-1:0] b1, input logic [N-1:0] b0);
        return {b3, b2, b1, b0};
    endfunction

    // Straight evaluation of the recurrence against the bench's own history.
    function automatic logic [N-1:0] model(input logic [N-1:0] y, input logic [(DELAYS+1)*N-1:0] bv);
        logic [N-1:0] a;
        logic [N-1:0] bk;
        a = y;
        for (int k = 1; k <= DELAYS; k++) begin
            bk = bv[k*N +: N];
            a  = a - bk * mh[k-1];
        end
        return a;
    endfunction

    // Scoreboard: compare on the cycle before each output handshake edge.
    always @(negedge clk) begin
        if (!rst && !clr && x_valid && x_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL x_unexpected: got %h expected no output", x_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("x_out", x_out, mon_exp);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the input handshake edge.
    task automatic send(input logic [N-1:0] y, input logic [N-1:0] exp, input bit push);
        int t;
        t       = 0;
        y_in    = y;
        y_valid = 1'b1;
        @(negedge clk);
        while (!y_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!y_ready) begin
            check_bit("y_ready_timeout", y_ready, 1'b1);
            y_valid = 1'b0;
            return;
        end
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        y_valid = 1'b0;
    endtask

    task automatic wait_xvalid(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (!x_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        check_bit(tag, x_valid, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", N'(exp_q.size()), '0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ry;
        logic [N-1:0] re;

        rst = 1'b1; clr = 1'b0; y_valid = 1'b0; y_in = '0; x_ready = 1'b1; b = '0;

        // ---- reset state
        @(negedge clk);
        check_bit("rst_y_ready", y_ready, 1'b0);
        check_bit("rst_x_valid", x_valid, 1'b0);
        check("rst_x_out", x_out, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_bit("post_rst_y_ready", y_ready, 1'b1);
        @(posedge clk); #1;

        // ---- impulse round trip: forward response of x=1,0,0,0
        b = mkb(32'd1, 32'hFFFF_FFFF, 32'd2, 32'd1);
        send(32'd1, 32'd1, 1'b1);
        send(32'd2, 32'd0, 1'b1);
        send(32'hFFFF_FFFF, 32'd0, 1'b1);
        send(32'd1, 32'd0, 1'b1);
        drain();

        // ---- latency with zero history; x_valid follows DELAYS ACC cycles
        pulse_clr();
        b = mkb(32'd0, 32'd0, 32'd0, 32'd1);
        y_in = 32'd5; y_valid = 1'b1;
        @(negedge clk);
        check_bit("lat_y_ready_pre", y_ready, 1'b1);
        exp_q.push_back(32'd5);
        @(posedge clk); #1;
        y_valid = 1'b0;
        for (int i = 0; i < DELAYS; i++) begin
            @(negedge clk);
            check_bit("lat_xv_low", x_valid, 1'b0);
            check_bit("lat_yr_low", y_ready, 1'b0);
        end
        @(negedge clk);
        check_bit("lat_xv_high", x_valid, 1'b1);
        check_bit("lat_yr_out", y_ready, 1'b0);
        @(negedge clk);
        check_bit("lat_yr_back", y_ready, 1'b1);
        check_bit("lat_xv_done", x_valid, 1'b0);
        @(posedge clk); #1;

        // ---- backpressure: OUT holds while x_ready is low
        x_ready = 1'b0;
        send(32'd9, 32'd9, 1'b1);
        wait_xvalid("bp_xv_wait");
        for (int i = 0; i < 5; i++) begin
            check_bit("bp_xv_hold", x_valid, 1'b1);
            check("bp_x_hold", x_out, 32'd9);
            check_bit("bp_yr_low", y_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        x_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("bp_xv_released", x_valid, 1'b0);
        check("bp_sb_empty", N'(exp_q.size()), '0);
        @(posedge clk); #1;

        // ---- wrap-around: b1 = -1, prior x = 1
        pulse_clr();
        b = mkb(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1);
        send(32'd1, 32'd1, 1'b1);
        send(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        drain();

        // ---- coefficient isolation: b changes mid-ACC, and b0 is ignored
        pulse_clr();
        b = mkb(32'd0, 32'd0, 32'd2, 32'd1);
        send(32'd1, 32'd1, 1'b1);
        send(32'd10, 32'd8, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        b = mkb(32'd0, 32'd0, 32'd7, 32'd1);
        drain();
        pulse_clr();
        b = mkb(32'd0, 32'd0, 32'd2, 32'd5);
        send(32'd1, 32'd1, 1'b1);
        send(32'd10, 32'd8, 1'b1);
        drain();

        // ---- asynchronous reset during ACC discards the sample and history
        pulse_clr();
        b = mkb(32'd1, 32'hFFFF_FFFF, 32'd2, 32'd1);
        send(32'd3, 32'd3, 1'b1);
        drain();
        send(32'd4, 32'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_bit("rst_mid_xv", x_valid, 1'b0);
        check_bit("rst_mid_yr", y_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(32'd7, 32'd7, 1'b1);
        drain();

        // ---- clr after three samples, with one sample stuck in OUT
        pulse_clr();
        send(32'd1, 32'd1, 1'b1);
        send(32'd2, 32'd0, 1'b1);
        send(32'hFFFF_FFFF, 32'd0, 1'b1);
        drain();
        x_ready = 1'b0;
        send(32'd5, 32'd0, 1'b0);
        wait_xvalid("clr_xv_wait");
        @(posedge clk); #1;
        clr = 1'b1;
        @(negedge clk);
        check_bit("clr_xv_before_edge", x_valid, 1'b1);
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check_bit("clr_xv_dropped", x_valid, 1'b0);
        check_bit("clr_yr_idle", y_ready, 1'b1);
        @(posedge clk); #1;
        x_ready = 1'b1;
        send(32'd7, 32'd7, 1'b1);
        drain();

        // ---- handshake coinciding with clr is ignored
        y_in = 32'd11; y_valid = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        y_valid = 1'b0; clr = 1'b0;
        @(negedge clk);
        check_bit("clr_hs_ignored", y_ready, 1'b1);
        repeat (DELAYS + 2) @(negedge clk);
        check_bit("clr_hs_no_out", x_valid, 1'b0);
        @(posedge clk); #1;

        // ---- random taps and samples against the recurrence
        pulse_clr();
        for (int i = 0; i < DELAYS; i++) mh[i] = '0;
        b = mkb($urandom, $urandom, $urandom, 32'd1);
        for (int n = 0; n < 8; n++) begin
            ry = $urandom;
            re = model(ry, b);
            for (int i = DELAYS - 1; i > 0; i--) mh[i] = mh[i-1];
            mh[0] = re;
            send(ry, re, 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
